// File: rtl/core_bus_arbiter.sv
// Single-beat memory port shared by the instruction and data buses.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default is data-bus priority.
module core_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  output logic              mreq_is_write,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_ready,
  input  logic              mresp_last,
  input  logic [DATA_W-1:0] mresp_data
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  state_t state;
  logic   grant_i;
  logic   grant_d;
  logic   beat_done;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = fetch granted last, 1 = data granted last
  logic last_grant;
`endif

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset && state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (dreq_valid && ireq_valid) begin
        grant_d = !last_grant;
        grant_i = last_grant;
      end else begin
        grant_d = dreq_valid;
        grant_i = ireq_valid;
      end
`else
      grant_d = dreq_valid;
      grant_i = ireq_valid && !dreq_valid;
`endif
    end
  end

  assign iresp_addr_ok = grant_i;
  assign dresp_addr_ok = grant_d;
  assign beat_done     = mresp_ready && mresp_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      iresp_data_ok <= 1'b0;
      iresp_data    <= '0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= '0;
      mreq_valid    <= 1'b0;
      mreq_is_write <= 1'b0;
      mreq_addr     <= '0;
      mreq_size     <= '0;
      mreq_strobe   <= '0;
      mreq_data     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant    <= 1'b0;
`endif
    end else begin
      iresp_data_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            mreq_valid    <= 1'b1;
            mreq_is_write <= |dreq_strobe;
            mreq_addr     <= dreq_addr;
            mreq_size     <= dreq_size;
            mreq_strobe   <= dreq_strobe;
            mreq_data     <= dreq_data;
            state         <= SERVE_D;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b1;
`endif
          end else if (grant_i) begin
            mreq_valid    <= 1'b1;
            mreq_is_write <= 1'b0;
            mreq_addr     <= ireq_addr;
            mreq_size     <= 3'd2;
            mreq_strobe   <= 8'h00;
            mreq_data     <= '0;
            state         <= SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b0;
`endif
          end
        end
        SERVE_I: begin
          if (beat_done) begin
            mreq_valid    <= 1'b0;
            iresp_data_ok <= 1'b1;
            iresp_data    <= mreq_addr[2] ? mresp_data[63:32]
                                          : mresp_data[31:0];
            state         <= DONE;
          end
        end
        SERVE_D: begin
          if (beat_done) begin
            mreq_valid    <= 1'b0;
            dresp_data_ok <= 1'b1;
            dresp_data    <= mreq_is_write ? '0 : mresp_data;
            state         <= DONE;
          end
        end
        // the core still shows the served request here; never re-grant
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter with a small latency memory model.
// Grant-order expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = '0;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = '0;
  logic [2:0]  dreq_size = '0;
  logic [7:0]  dreq_strobe = '0;
  logic [63:0] dreq_data = '0;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic        mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ready;
  logic        mresp_last = 1'b1;
  logic [63:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail = 0;
  int mem_lat = 2;
  int mcnt = 0;
  int txns = 0;
  logic mq = 1'b0;

  always #5 clk = ~clk;

  core_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_is_write(mreq_is_write),
    .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_ready(mresp_ready), .mresp_last(mresp_last),
    .mresp_data(mem_rdata)
  );

  // ready rises mem_lat cycles after the first mreq_valid cycle
  always @(posedge clk) begin
    if (reset) begin
      mcnt <= 0;
      mresp_ready <= 1'b0;
    end else if (mresp_ready) begin
      mresp_ready <= 1'b0;
      mcnt <= 0;
    end else if (mreq_valid) begin
      mcnt <= mcnt + 1;
      mresp_ready <= (mcnt + 1 >= mem_lat);
    end
  end

  always @(posedge clk) begin
    mq <= mreq_valid;
    if (mreq_valid && !mq) txns <= txns + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    nxt;
    reset = 1'b1;
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    nxt;
    reset = 1'b0;
  endtask

  // advance until the data_ok of the given bus; cycle numbers from base
  task automatic serve(input bit is_d, input int base,
                       output int rdy, output int ok);
    rdy = -1;
    ok = -1;
    for (int c = base + 1; c <= base + 40 && ok < 0; c++) begin
      nxt;
      @(negedge clk);
      if (rdy < 0 && mresp_ready) rdy = c;
      chk("aok_busy", {62'd0, iresp_addr_ok, dresp_addr_ok}, 64'd0);
      chk("ok_other", is_d ? iresp_data_ok : dresp_data_ok, 64'd0);
      if (is_d ? dresp_data_ok : iresp_data_ok) ok = c;
    end
    chk("serve_done", 64'(ok > 0), 64'd1);
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 8 && g < 0; c++) begin
      @(negedge clk);
      chk("both_aok", 64'(iresp_addr_ok && dresp_addr_ok), 64'd0);
      if (dresp_addr_ok) g = 1;
      else if (iresp_addr_ok) g = 0;
      else nxt;
    end
    chk("grant_seen", 64'(g >= 0), 64'd1);
  endtask

  int rdy, ok, t0, g;
  int exp_g [4];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{1, 0, 1, 0};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    // reset state, with a fetch pending to check addr_ok gating
    ireq_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_iaok", iresp_addr_ok, 0);
    chk("rst_mvalid", mreq_valid, 0);
    chk("rst_idok", {iresp_data_ok, dresp_data_ok}, 0);
    chk("rst_mreq", {mreq_addr ^ mreq_data, 3'd0} | mreq_strobe, 0);
    ireq_valid = 1'b0;
    nxt;
    reset = 1'b0;

    // fetch, upper word, requester holds valid through DONE
    nxt;
    t0 = txns;
    ireq_valid = 1'b1;
    ireq_addr = 64'h8000_0004;
    mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("f_iaok", iresp_addr_ok, 1);
    chk("f_daok", dresp_addr_ok, 0);
    chk("f_mv0", mreq_valid, 0);
    nxt;
    @(negedge clk);
    chk("f_mv1", mreq_valid, 1);
    chk("f_size", mreq_size, 2);
    chk("f_wr", {mreq_is_write, mreq_strobe}, 0);
    chk("f_addr", mreq_addr, 64'h8000_0004);
    serve(0, 1, rdy, ok);
    chk("f_rdy", rdy, 3);
    chk("f_ok", ok, 4);
    chk("f_data", iresp_data, 32'h1111_2222);
    nxt;
    ireq_valid = 1'b0;
    @(negedge clk);
    chk("f_pulse", iresp_data_ok, 0);
    chk("f_nodup", mreq_valid, 0);
    nxt;
    @(negedge clk);
    chk("f_txns", txns - t0, 1);

    // store; inputs scrambled after accept
    nxt;
    dreq_valid = 1'b1;
    dreq_addr = 64'h8000_0010;
    dreq_size = 3'd2;
    dreq_strobe = 8'h0F;
    dreq_data = 64'hAABB_CCDD;
    mem_rdata = 64'h1234_5678;
    @(negedge clk);
    chk("s_daok", dresp_addr_ok, 1);
    chk("s_iaok", iresp_addr_ok, 0);
    nxt;
    dreq_valid = 1'b0;
    dreq_addr = '1;
    dreq_data = '1;
    dreq_strobe = 8'h00;
    dreq_size = 3'd0;
    @(negedge clk);
    chk("s_mv", mreq_valid, 1);
    chk("s_wr", mreq_is_write, 1);
    chk("s_strb", mreq_strobe, 8'h0F);
    chk("s_addr", mreq_addr, 64'h8000_0010);
    chk("s_data", mreq_data, 64'hAABB_CCDD);
    chk("s_size", mreq_size, 2);
    serve(1, 1, rdy, ok);
    chk("s_ok", ok, 4);
    chk("s_rdata", dresp_data, 0);
    nxt;
    @(negedge clk);
    chk("s_pulse", dresp_data_ok, 0);

    // 64-bit read, valid dropped right after accept
    nxt;
    dreq_valid = 1'b1;
    dreq_addr = 64'h100;
    dreq_size = 3'd3;
    dreq_strobe = 8'h00;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    chk("r_daok", dresp_addr_ok, 1);
    nxt;
    dreq_valid = 1'b0;
    @(negedge clk);
    chk("r_wr", mreq_is_write, 0);
    chk("r_size", mreq_size, 3);
    serve(1, 1, rdy, ok);
    chk("r_data", dresp_data, 64'hDEAD_BEEF_CAFE_F00D);

    // fetch lower word, flushed after accept
    nxt;
    ireq_valid = 1'b1;
    ireq_addr = 64'h8000_0008;
    mem_rdata = 64'h5555_6666_7777_8888;
    @(negedge clk);
    chk("l_iaok", iresp_addr_ok, 1);
    nxt;
    ireq_valid = 1'b0;
    serve(0, 1, rdy, ok);
    chk("l_data", iresp_data, 32'h7777_8888);

    // single conflict: data first, then the still-pending fetch
    do_reset;
    ireq_valid = 1'b1;
    ireq_addr = 64'h200;
    dreq_valid = 1'b1;
    dreq_addr = 64'h300;
    dreq_strobe = 8'h00;
    @(negedge clk);
    chk("c_daok", dresp_addr_ok, 1);
    chk("c_iaok", iresp_addr_ok, 0);
    nxt;
    dreq_valid = 1'b0;
    serve(1, 1, rdy, ok);
    nxt;
    @(negedge clk);
    chk("c_iaok2", iresp_addr_ok, 1);
    nxt;
    ireq_valid = 1'b0;
    @(negedge clk);
    chk("c_iaddr", mreq_addr, 64'h200);
    serve(0, 1, rdy, ok);

    // both buses request continuously: four grants
    do_reset;
    ireq_valid = 1'b1;
    dreq_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      chk($sformatf("grant%0d", k), 64'(g), 64'(exp_g[k]));
      serve(g == 1, 0, rdy, ok);
      nxt;
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;

    // reset while data request waits on slow memory
    do_reset;
    mem_lat = 10;
    dreq_valid = 1'b1;
    dreq_addr = 64'h400;
    dreq_strobe = 8'h00;
    @(negedge clk);
    chk("x_daok", dresp_addr_ok, 1);
    nxt;
    dreq_valid = 1'b0;
    nxt;
    nxt;
    @(negedge clk);
    chk("x_mv", mreq_valid, 1);
    nxt;
    reset = 1'b1;
    @(negedge clk);
    chk("x_sync", mreq_valid, 1);
    nxt;
    reset = 1'b0;
    mem_lat = 2;
    @(negedge clk);
    chk("x_mv0", mreq_valid, 0);
    for (int k = 0; k < 12; k++) begin
      nxt;
      @(negedge clk);
      chk("x_quiet", {mreq_valid, iresp_data_ok, dresp_data_ok}, 0);
    end
    nxt;
    ireq_valid = 1'b1;
    ireq_addr = 64'h8000_0000;
    mem_rdata = 64'h0BAD_F00D_1357_9BDF;
    @(negedge clk);
    chk("x_iaok", iresp_addr_ok, 1);
    nxt;
    ireq_valid = 1'b0;
    serve(0, 1, rdy, ok);
    chk("x_ok", ok, 4);
    chk("x_data", iresp_data, 32'h1357_9BDF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
